fetch_controller: RTL and testbench

//  Consumer end of the program-counter interface: takes ProgramCounter as the fetch

---
 rtl/fetch_controller.sv | 103 ++++++++++
 tb/tb_fetch_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Fetch controller: reads program memory at ProgramCounter with a req/ack handshake,
// buffers fetched words in a small FIFO for decode and holds the PC until a word lands.
module fetch_controller #(
  parameter int ADDR_W  = 7,
  parameter int INSTR_W = 24,
  parameter int QDEPTH  = 2
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic [ADDR_W-1:0]  ProgramCounter,
  output logic               PCHold,
  output logic               MemReq,
  output logic [ADDR_W-1:0]  MemAddr,
  input  logic               MemAck,
  input  logic [INSTR_W-1:0] MemData,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrAddr
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_SPACE} state_t;

  state_t             state_q;
  logic               req_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_mem [QDEPTH];
  logic [INSTR_W-1:0] data_mem [QDEPTH];
  logic               push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // req_q mirrors state_q==REQ, so an ack in any other state is ignored
  assign push    = req_q && MemAck;
  assign pop     = (count_q != '0) && InstrReady;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  assign rd_d    = pop  ? ptr_inc(rd_q) : rd_q;
  assign wr_d    = push ? ptr_inc(wr_q) : wr_q;

  assign MemReq     = req_q;
  assign MemAddr    = ProgramCounter;
  assign PCHold     = ~push;
  assign InstrValid = (count_q != '0);
  assign Instr      = InstrValid ? data_mem[rd_q] : '0;
  assign InstrAddr  = InstrValid ? addr_mem[rd_q] : '0;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (push && count_d == CNT_W'(QDEPTH)) begin
            state_q <= WAIT_SPACE;
            req_q   <= 1'b0;
          end
        end
        WAIT_SPACE: begin
          if (count_q < CNT_W'(QDEPTH)) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Storage needs no reset: outputs are gated by the count
  always_ff @(posedge Clock) begin
    if (push) begin
      addr_mem[wr_q] <= ProgramCounter;
      data_mem[wr_q] <= MemData;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: emulates the program counter and ROM, scoreboards the
// fetched stream against the expected consecutive address sequence.
module tb_fetch_controller;

  localparam int ADDR_W  = 7;
  localparam int INSTR_W = 24;
  localparam int QDEPTH  = 2;

  logic               Clock;
  logic               nReset;
  logic [ADDR_W-1:0]  ProgramCounter;
  logic               PCHold;
  logic               MemReq;
  logic [ADDR_W-1:0]  MemAddr;
  logic               MemAck;
  logic [INSTR_W-1:0] MemData;
  logic               InstrValid;
  logic               InstrReady;
  logic [INSTR_W-1:0] Instr;
  logic [ADDR_W-1:0]  InstrAddr;

  fetch_controller #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH)) dut (
    .Clock(Clock), .nReset(nReset), .ProgramCounter(ProgramCounter), .PCHold(PCHold),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrAddr(InstrAddr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int                 tests = 0;
  int                 fails = 0;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_exp;
  int                 model_cnt;
  logic [INSTR_W-1:0] salt;

  function automatic logic [INSTR_W-1:0] rom(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 7'h2a, 3'b101} ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check before the rising edge, update model after it
  task automatic cycle(input bit ack, input bit rdy, input int exp_req);
    bit push, pop, hold;
    @(negedge Clock);
    ProgramCounter = pc;
    MemAck         = ack;
    InstrReady     = rdy;
    MemData        = rom(pc);
    #1;
    if (exp_req != 2) chk("memreq", {31'd0, MemReq}, exp_req);
    chk("pchold_rule", {31'd0, PCHold}, {31'd0, ~(MemReq & ack)});
    chk("memaddr", {25'd0, MemAddr}, {25'd0, pc});
    chk("instr_valid", {31'd0, InstrValid}, {31'd0, model_cnt > 0});
    push = MemReq && ack;
    pop  = InstrValid && rdy;
    hold = PCHold;
    if (pop) begin
      chk("instr_addr", {25'd0, InstrAddr}, {25'd0, next_exp});
      chk("instr_data", {8'd0, Instr}, {8'd0, rom(next_exp)});
      next_exp = next_exp + 1'b1;
    end
    @(posedge Clock);
    model_cnt = model_cnt + int'(push) - int'(pop);
    if (push) chk("no_overflow", {31'd0, model_cnt <= QDEPTH}, 32'd1);
    if (!hold) pc = pc + 1'b1;
  endtask

  // Assert reset at a negedge with a stray ack present; release just after a rising edge
  task automatic do_reset(input logic [ADDR_W-1:0] start);
    @(negedge Clock);
    nReset     = 1'b0;
    MemAck     = 1'b1;
    InstrReady = 1'b0;
    MemData    = rom(pc);
    #1;
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_pchold", {31'd0, PCHold}, 32'd1);
    chk("rst_instr", {8'd0, Instr}, 32'd0);
    chk("rst_instraddr", {25'd0, InstrAddr}, 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_ack_ignored", {31'd0, PCHold}, 32'd1);
    chk("rst_valid_hold", {31'd0, InstrValid}, 32'd0);
    pc             = start;
    next_exp       = start;
    model_cnt      = 0;
    ProgramCounter = start;
    MemAck         = 1'b0;
    nReset         = 1'b1;
  endtask

  initial begin
    nReset         = 1'b0;
    MemAck         = 1'b0;
    InstrReady     = 1'b0;
    MemData        = '0;
    pc             = '0;
    ProgramCounter = '0;
    next_exp       = '0;
    model_cnt      = 0;
    salt           = INSTR_W'($urandom);

    // Zero-wait memory, decode always ready: one fetch per cycle after IDLE
    do_reset(7'd0);
    cycle(1, 1, 0);
    repeat (8) cycle(1, 1, 1);
    chk("t1_pc", {25'd0, pc}, 32'd8);
    chk("t1_popped", {25'd0, next_exp}, 32'd7);

    // Three wait cycles per request
    do_reset(7'd10);
    cycle(0, 1, 0);
    repeat (3) begin
      repeat (3) cycle(0, 1, 1);
      cycle(1, 1, 1);
    end
    cycle(0, 1, 1);
    chk("t2_pc", {25'd0, pc}, 32'd13);
    chk("t2_popped", {25'd0, next_exp}, 32'd13);

    // Decode stalled: queue fills, then drains and fetch resumes
    do_reset(7'd0);
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("t3_pc_held", {25'd0, pc}, 32'd2);
    chk("t3_queued", model_cnt, QDEPTH);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    chk("t3_resume_pc", {25'd0, pc}, 32'd4);

    // PC wrap-around
    do_reset(7'd126);
    cycle(1, 1, 0);
    repeat (4) cycle(1, 1, 1);
    cycle(0, 1, 1);
    chk("t5_wrap_popped", {25'd0, next_exp}, 32'd2);

    // Reset in REQ with one word queued
    do_reset(7'd0);
    cycle(0, 0, 0);
    cycle(1, 0, 1);
    cycle(0, 0, 1);
    chk("t6_queued", model_cnt, 1);
    do_reset(7'd0);
    cycle(1, 1, 0);
    cycle(1, 1, 1);
    cycle(0, 1, 1);
    chk("t6_restart", {25'd0, next_exp}, 32'd1);

    // Random ack/ready traffic against the scoreboard
    do_reset(ADDR_W'($urandom_range(0, 127)));
    cycle(bit'($urandom_range(0, 1)), 1'b0, 0);
    repeat (400) cycle(bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 3) != 0), 2);
    repeat (4) cycle(0, 1, 2);
    chk("rand_drained", {31'd0, InstrValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
